// File: rtl/input_stage_pkg.sv
// Shared types and sizing helpers for the switch input stage.
package input_stage_pkg;

  localparam int SW_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    WAIT_RELEASE
  } stateT;

  // Wide enough to hold DEBOUNCE_CYCLES itself so a counter can saturate at it.
  function automatic int counterWidth(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser and debounce counter for one active-low push button.
module debounce_filter
  import input_stage_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic RawN,
  output logic Level
);

  localparam int CNT_W = counterWidth(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic syncMeta;
  logic syncStable;
  logic pressed;
  logic [CNT_W-1:0] count;

  // Synchroniser idles at 1 so a released button is seen straight out of reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      syncMeta   <= 1'b1;
      syncStable <= 1'b1;
    end else begin
      syncMeta   <= RawN;
      syncStable <= syncMeta;
    end
  end

  assign pressed = ~syncStable;

  // Level only flips after the synced input has disagreed with it for the full window.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      Level <= 1'b0;
    end else if (pressed == Level) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
      Level <= ~Level;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/switch_input_stage.sv
// IN-instruction input stage: synchronised switches, debounced button, capture handshake.
// Optional macro SW_STABLE_EN: capture also waits for the switch word to settle.
module switch_input_stage
  import input_stage_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_W            = SW_W_DEFAULT
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            ButtonRaw,
  input  logic [SW_W-1:0] SwitchesRaw,
  input  logic            InRequest,
  output logic [SW_W-1:0] SwitchData,
  output logic            DataValid,
  output logic            Waiting,
  output logic            ButtonLevel
);

  stateT state;
  stateT nextState;

  logic [SW_W-1:0] swMeta;
  logic [SW_W-1:0] swSync;
  logic            levelQ;
  logic            pressEvent;
  logic            pressReady;
  logic            settled;
  logic            captureNow;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) buttonFilter (
    .Clock (Clock),
    .Reset (Reset),
    .RawN  (ButtonRaw),
    .Level (ButtonLevel)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      swMeta <= '0;
      swSync <= '0;
      levelQ <= 1'b0;
    end else begin
      swMeta <= SwitchesRaw;
      swSync <= swMeta;
      levelQ <= ButtonLevel;
    end
  end

  assign pressEvent = ButtonLevel & ~levelQ;

`ifdef SW_STABLE_EN
  localparam int CNT_W = counterWidth(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] stableCount;
  logic             pressSeen;

  // Restarts on the edge the synced word changes, then saturates once settled.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stableCount <= '0;
    end else if (swMeta != swSync) begin
      stableCount <= '0;
    end else if (stableCount != STABLE_MAX) begin
      stableCount <= stableCount + 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pressSeen <= 1'b0;
    end else if (state == ARMED && InRequest) begin
      pressSeen <= pressSeen | pressEvent;
    end else begin
      pressSeen <= 1'b0;
    end
  end

  assign pressReady = pressSeen | pressEvent;
  assign settled    = (stableCount == STABLE_MAX);
`else
  assign pressReady = pressEvent;
  assign settled    = 1'b1;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Cancel wins over a same-cycle press; only a fresh press edge while armed captures.
  always_comb begin
    nextState  = state;
    captureNow = 1'b0;
    Waiting    = 1'b0;
    DataValid  = 1'b0;
    case (state)
      IDLE: begin
        if (InRequest) nextState = ARMED;
      end
      ARMED: begin
        Waiting = 1'b1;
        if (!InRequest) begin
          nextState = IDLE;
        end else if (pressReady && settled) begin
          nextState  = CAPTURE;
          captureNow = 1'b1;
        end
      end
      CAPTURE: begin
        DataValid = 1'b1;
        nextState = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!ButtonLevel && !InRequest) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      SwitchData <= '0;
    end else if (captureNow) begin
      SwitchData <= swSync;
    end
  end

endmodule
